// File: rtl/mem_arbiter.sv
// Single-port memory sequencer shared by instruction fetch and data load/store.
// Arbitrates between the two requesters with a bounded data-priority streak,
// performs read-modify-write for sub-doubleword stores and flags misaligned
// accesses without touching memory. All outputs are registered.
module mem_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic [63:0] d_rdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;
  localparam int SW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CW-1:0] LAT_LAST   = CW'(MEM_LAT);
  localparam logic [SW-1:0] STREAK_LIM = SW'(STARVE_MAX);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RMW_RD,
    RMW_WR,
    WR,
    ACK
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [SW-1:0] streak;

  // Transaction context captured at grant; requester inputs are ignored afterwards.
  logic          cur_fetch;
  logic [1:0]    cur_size;
  logic [2:0]    cur_offset;
  logic [63:0]   cur_wdata;

  logic          pick_fetch;
  logic [31:0]   sel_addr;
  logic [1:0]    sel_size;
  logic          sel_misaligned;
  logic [63:0]   merged;

  // Arbitration and alignment check for the request that would be granted this cycle.
  always_comb begin
    pick_fetch = if_req && (!d_req || (streak == STREAK_LIM));
    sel_addr   = pick_fetch ? if_addr : d_addr;
    sel_size   = pick_fetch ? 2'd2 : d_size;
    case (sel_size)
      2'd0:    sel_misaligned = 1'b0;
      2'd1:    sel_misaligned = sel_addr[0];
      2'd2:    sel_misaligned = |sel_addr[1:0];
      default: sel_misaligned = |sel_addr[2:0];
    endcase
  end

  // Replace the addressed lane of the doubleword just read with the store data.
  always_comb begin
    merged = mem_rdata;
    case (cur_size)
      2'd0:    merged[{cur_offset[2:0], 3'b000} +: 8]  = cur_wdata[7:0];
      2'd1:    merged[{cur_offset[2:1], 4'b0000} +: 16] = cur_wdata[15:0];
      2'd2:    merged[{cur_offset[2], 5'b00000} +: 32]  = cur_wdata[31:0];
      default: merged = cur_wdata;
    endcase
  end

  // Sequencer: grant, memory access timing, write strobes and completion pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      streak     <= '0;
      cur_fetch  <= 1'b0;
      cur_size   <= 2'd0;
      cur_offset <= 3'd0;
      cur_wdata  <= '0;
      if_rdata   <= '0;
      if_ack     <= 1'b0;
      if_err     <= 1'b0;
      d_rdata    <= '0;
      d_ack      <= 1'b0;
      d_err      <= 1'b0;
      mem_addr   <= '0;
      mem_wr     <= 1'b0;
      mem_wdata  <= '0;
    end else begin
      if (!if_req) begin
        streak <= '0;
      end
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            cur_fetch  <= pick_fetch;
            cur_size   <= sel_size;
            cur_offset <= sel_addr[2:0];
            cur_wdata  <= d_wdata;
            wait_cnt   <= '0;
            if (pick_fetch) begin
              streak <= '0;
            end else if (if_req) begin
              streak <= streak + SW'(1);
            end
            if (sel_misaligned) begin
              state  <= ACK;
              if_ack <= pick_fetch;
              if_err <= pick_fetch;
              d_ack  <= !pick_fetch;
              d_err  <= !pick_fetch;
            end else begin
              mem_addr <= {sel_addr[31:3], 3'b000};
              if (pick_fetch || !d_we) begin
                state <= RD;
              end else if (d_size == 2'd3) begin
                state     <= WR;
                mem_wr    <= 1'b1;
                mem_wdata <= d_wdata;
              end else begin
                state <= RMW_RD;
              end
            end
          end
        end
        RD: begin
          if (wait_cnt == LAT_LAST) begin
            state    <= ACK;
            mem_addr <= '0;
            if (cur_fetch) begin
              if_rdata <= cur_offset[2] ? mem_rdata[63:32] : mem_rdata[31:0];
              if_ack   <= 1'b1;
            end else begin
              d_rdata <= mem_rdata;
              d_ack   <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        RMW_RD: begin
          if (wait_cnt == LAT_LAST) begin
            state     <= RMW_WR;
            mem_wr    <= 1'b1;
            mem_wdata <= merged;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        RMW_WR, WR: begin
          state    <= ACK;
          mem_wr   <= 1'b0;
          mem_addr <= '0;
          d_ack    <= 1'b1;
        end
        ACK: begin
          state  <= IDLE;
          if_ack <= 1'b0;
          if_err <= 1'b0;
          d_ack  <= 1'b0;
          d_err  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a latency-accurate memory model drives
// mem_rdata, and a transaction-level reference (byte-lane arithmetic over a
// mirror memory) predicts every result, latency and write strobe.
module tb_mem_arbiter;

  localparam int MEM_LAT    = 1;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        if_err;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [1:0]  d_size = 2'd0;
  logic [31:0] d_addr = '0;
  logic [63:0] d_wdata = '0;
  logic [63:0] d_rdata;
  logic        d_ack;
  logic        d_err;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  mem_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Physical memory seen by the DUT, with a preset port and MEM_LAT read pipeline.
  logic [63:0] mem [256];
  logic [63:0] rd_pipe [MEM_LAT];
  logic        pre_en = 1'b0;
  logic [7:0]  pre_idx = '0;
  logic [63:0] pre_val = '0;

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    else if (mem_wr) mem[mem_addr[10:3]] <= mem_wdata;
    rd_pipe[0] <= mem[mem_addr[10:3]];
    for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[MEM_LAT-1];

  logic [63:0] ref_mem [256];
  int total = 0;
  int bad = 0;
  logic [31:0] exp_if_rdata = '0;
  logic [63:0] exp_d_rdata = '0;

  int          r_lat;
  bit          r_if, r_d, r_err;
  int          r_wr_cnt, r_wr_k;
  logic [31:0] r_wr_addr;
  logic [63:0] r_wr_data;

  function automatic bit model_misaligned(bit fetch, logic [1:0] size, logic [31:0] a);
    int nb;
    nb = fetch ? 4 : (1 << size);
    return (a % nb) != 0;
  endfunction

  function automatic int model_latency(bit fetch, bit we, logic [1:0] size, logic [31:0] a);
    if (model_misaligned(fetch, size, a)) return 1;
    if (fetch || !we) return MEM_LAT + 2;
    if (size == 2'd3) return 2;
    return MEM_LAT + 3;
  endfunction

  function automatic logic [63:0] model_store(logic [63:0] old, logic [1:0] size,
                                              logic [31:0] a, logic [63:0] wd);
    logic [63:0] res;
    int off, nb;
    res = old;
    off = a % 8;
    nb = 1 << size;
    for (int i = 0; i < nb; i++) res[(off + i) * 8 +: 8] = wd[i * 8 +: 8];
    return res;
  endfunction

  function automatic logic [31:0] model_fetch(logic [31:0] a);
    logic [63:0] dw;
    dw = ref_mem[a[10:3]] >> (32 * ((a % 8) / 4));
    return dw[31:0];
  endfunction

  task automatic preset(input int idx, input logic [63:0] v);
    pre_en = 1'b1;
    pre_idx = 8'(idx);
    pre_val = v;
    @(posedge clk);
    #1 pre_en = 1'b0;
    ref_mem[idx] = v;
  endtask

  // Issue one request, then watch strobes until the completion pulse or a cycle budget.
  task automatic run_txn(input bit fetch, input bit we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [63:0] wdata);
    @(negedge clk);
    if (fetch) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      d_req = 1'b1; d_we = we; d_size = size; d_addr = addr; d_wdata = wdata;
    end
    r_lat = 0; r_if = 0; r_d = 0; r_err = 0; r_wr_cnt = 0; r_wr_k = 0;
    r_wr_addr = '0; r_wr_data = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (mem_wr) begin
        r_wr_cnt++; r_wr_k = k; r_wr_addr = mem_addr; r_wr_data = mem_wdata;
      end
      if (if_ack || d_ack) begin
        r_lat = k; r_if = if_ack; r_d = d_ack; r_err = if_err | d_err;
        break;
      end
      if (k == 1) begin
        if_addr = $urandom; d_addr = $urandom; d_wdata = {$urandom, $urandom};
        d_size = 2'($urandom); d_we = 1'($urandom);
      end
    end
    if_req = 1'b0;
    d_req = 1'b0;
  endtask

  task automatic test_reset;
    int seen;
    seen = 0;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'd3; d_addr = 32'h100;
    repeat (3) begin
      @(negedge clk);
      if (d_ack || if_ack || mem_wr || mem_addr != 0) seen++;
    end
    d_req = 1'b0;
    total++;
    if (seen !== 0) begin bad++; $display("FAIL reset_ignore_req: activity=%0d want 0", seen); end
    total++;
    if ({if_ack, if_err, d_ack, d_err, mem_wr} !== 5'b0) begin
      bad++; $display("FAIL reset_strobes: got %b want 00000", {if_ack, if_err, d_ack, d_err, mem_wr});
    end
    total++;
    if ({if_rdata, d_rdata, mem_addr, mem_wdata} !== '0) begin
      bad++; $display("FAIL reset_data: if_rdata=%h d_rdata=%h mem_addr=%h mem_wdata=%h want 0",
                      if_rdata, d_rdata, mem_addr, mem_wdata);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fetch;
    preset(32'h100 >> 3, 64'h11223344_55667788);
    run_txn(1'b1, 1'b0, 2'd2, 32'h104, '0);
    exp_if_rdata = model_fetch(32'h104);
    total++;
    if (r_lat !== 3 || r_if !== 1'b1 || r_d !== 1'b0) begin
      bad++; $display("FAIL fetch_ack: lat=%0d if=%b d=%b want lat=3 if=1 d=0", r_lat, r_if, r_d);
    end
    total++;
    if (if_rdata !== 32'h11223344) begin
      bad++; $display("FAIL fetch_data: got %h want 11223344", if_rdata);
    end
    total++;
    if (r_err !== 1'b0 || r_wr_cnt !== 0) begin
      bad++; $display("FAIL fetch_side: err=%b writes=%0d want 0 0", r_err, r_wr_cnt);
    end
  endtask

  task automatic test_store_byte;
    preset(32'h200 >> 3, 64'h0);
    run_txn(1'b0, 1'b1, 2'd0, 32'h203, 64'hAB);
    ref_mem[32'h200 >> 3] = model_store(64'h0, 2'd0, 32'h203, 64'hAB);
    total++;
    if (r_wr_cnt !== 1 || r_wr_data !== 64'h00000000_AB000000 || r_wr_addr !== 32'h200) begin
      bad++; $display("FAIL sb_write: cnt=%0d addr=%h data=%h want 1 200 00000000ab000000",
                      r_wr_cnt, r_wr_addr, r_wr_data);
    end
    total++;
    if (r_lat !== MEM_LAT + 3 || r_d !== 1'b1 || r_err !== 1'b0) begin
      bad++; $display("FAIL sb_ack: lat=%0d d=%b err=%b want %0d 1 0", r_lat, r_d, r_err, MEM_LAT + 3);
    end
    total++;
    if (d_rdata !== exp_d_rdata) begin
      bad++; $display("FAIL sb_rdata_hold: got %h want %h", d_rdata, exp_d_rdata);
    end
  endtask

  task automatic test_store_dword;
    run_txn(1'b0, 1'b1, 2'd3, 32'h208, 64'hDEADBEEF_CAFEF00D);
    ref_mem[32'h208 >> 3] = 64'hDEADBEEF_CAFEF00D;
    total++;
    if (r_wr_cnt !== 1 || r_wr_k !== 1 || r_wr_addr !== 32'h208 || r_wr_data !== 64'hDEADBEEF_CAFEF00D) begin
      bad++; $display("FAIL sd_write: cnt=%0d cyc=%0d addr=%h data=%h want 1 1 208 deadbeefcafef00d",
                      r_wr_cnt, r_wr_k, r_wr_addr, r_wr_data);
    end
    total++;
    if (r_lat !== 2 || r_d !== 1'b1) begin
      bad++; $display("FAIL sd_ack: lat=%0d d=%b want 2 1", r_lat, r_d);
    end
    run_txn(1'b0, 1'b0, 2'd3, 32'h208, '0);
    exp_d_rdata = ref_mem[32'h208 >> 3];
    total++;
    if (d_rdata !== 64'hDEADBEEF_CAFEF00D || r_lat !== MEM_LAT + 2) begin
      bad++; $display("FAIL sd_readback: got %h lat=%0d want deadbeefcafef00d lat=%0d",
                      d_rdata, r_lat, MEM_LAT + 2);
    end
  endtask

  task automatic test_misaligned;
    run_txn(1'b0, 1'b0, 2'd2, 32'h102, '0);
    total++;
    if (r_lat !== 1 || r_d !== 1'b1 || r_err !== 1'b1 || r_wr_cnt !== 0) begin
      bad++; $display("FAIL mis_lw: lat=%0d d=%b err=%b writes=%0d want 1 1 1 0", r_lat, r_d, r_err, r_wr_cnt);
    end
    run_txn(1'b0, 1'b1, 2'd3, 32'h104, 64'h5555);
    total++;
    if (r_lat !== 1 || r_err !== 1'b1 || r_wr_cnt !== 0 || mem[32'h100 >> 3] !== ref_mem[32'h100 >> 3]) begin
      bad++; $display("FAIL mis_sd: lat=%0d err=%b writes=%0d mem=%h want 1 1 0 %h",
                      r_lat, r_err, r_wr_cnt, mem[32'h100 >> 3], ref_mem[32'h100 >> 3]);
    end
    run_txn(1'b1, 1'b0, 2'd2, 32'h101, '0);
    total++;
    if (r_lat !== 1 || r_if !== 1'b1 || r_err !== 1'b1 || if_rdata !== exp_if_rdata) begin
      bad++; $display("FAIL mis_fetch: lat=%0d if=%b err=%b data=%h want 1 1 1 %h",
                      r_lat, r_if, r_err, if_rdata, exp_if_rdata);
    end
  endtask

  task automatic test_random;
    bit fetch, we, mis, ewr;
    logic [1:0] size;
    logic [31:0] addr, eaddr;
    logic [63:0] wdata, edata;
    int elat, nb;
    for (int n = 0; n < 40; n++) begin
      fetch = ($urandom_range(0, 2) == 0);
      we = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      addr = $urandom_range(0, 2047);
      nb = fetch ? 4 : (1 << size);
      if ($urandom_range(0, 3) != 0) addr = addr - (addr % nb);
      wdata = {$urandom, $urandom};
      mis = model_misaligned(fetch, size, addr);
      elat = model_latency(fetch, we, size, addr);
      ewr = !fetch && we && !mis;
      eaddr = addr - (addr % 8);
      edata = model_store(ref_mem[addr[10:3]], size, addr, wdata);
      run_txn(fetch, we, size, addr, wdata);
      if (ewr) ref_mem[addr[10:3]] = edata;
      if (!mis && fetch) exp_if_rdata = model_fetch(addr);
      if (!mis && !fetch && !we) exp_d_rdata = ref_mem[addr[10:3]];
      total++;
      if (r_lat !== elat || {r_if, r_d} !== {fetch, !fetch} || r_err !== mis) begin
        bad++; $display("FAIL rnd_ack[%0d]: lat=%0d if=%b d=%b err=%b want %0d %b %b %b",
                        n, r_lat, r_if, r_d, r_err, elat, fetch, !fetch, mis);
      end
      total++;
      if (r_wr_cnt !== int'(ewr) || (ewr && (r_wr_addr !== eaddr || r_wr_data !== edata))) begin
        bad++; $display("FAIL rnd_write[%0d]: cnt=%0d addr=%h data=%h want %0d %h %h",
                        n, r_wr_cnt, r_wr_addr, r_wr_data, ewr, eaddr, edata);
      end
      if (!mis) begin
        total++;
        if (if_rdata !== exp_if_rdata || d_rdata !== exp_d_rdata) begin
          bad++; $display("FAIL rnd_rdata[%0d]: if=%h d=%h want %h %h",
                          n, if_rdata, d_rdata, exp_if_rdata, exp_d_rdata);
        end
      end
    end
  endtask

  task automatic test_starvation;
    bit exp_f [10];
    bit obs_f [10];
    int cnt, s;
    s = 0;
    for (int n = 0; n < 10; n++) begin
      if (s == STARVE_MAX) begin exp_f[n] = 1'b1; s = 0; end
      else begin exp_f[n] = 1'b0; s++; end
    end
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'd3; d_addr = 32'h200;
    cnt = 0;
    for (int k = 0; k < 400 && cnt < 10; k++) begin
      @(negedge clk);
      if (if_ack && cnt < 10) begin obs_f[cnt] = 1'b1; cnt++; end
      if (d_ack && cnt < 10) begin obs_f[cnt] = 1'b0; cnt++; end
    end
    if_req = 1'b0;
    d_req = 1'b0;
    total++;
    if (cnt !== 10) begin bad++; $display("FAIL starve_count: got %0d acks want 10", cnt); end
    for (int n = 0; n < cnt; n++) begin
      total++;
      if (obs_f[n] !== exp_f[n]) begin
        bad++; $display("FAIL starve_grant[%0d]: got %s want %s", n, obs_f[n] ? "F" : "D", exp_f[n] ? "F" : "D");
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    bit found;
    int kk, acks, idx;
    logic [63:0] emerge;
    idx = 32'h30A >> 3;
    emerge = model_store(ref_mem[idx], 2'd1, 32'h30A, 64'h12345678_9ABCBEEF);
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_size = 2'd1; d_addr = 32'h30A; d_wdata = 64'h12345678_9ABCBEEF;
    found = 0; kk = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mem_wr) begin found = 1; kk = k; break; end
    end
    total++;
    if (!found || kk !== MEM_LAT + 2 || mem_wdata !== emerge) begin
      bad++; $display("FAIL rst_mid_rmw: found=%b cyc=%0d data=%h want 1 %0d %h",
                      found, kk, mem_wdata, MEM_LAT + 2, emerge);
    end
    reset = 1'b1;
    d_req = 1'b0;
    ref_mem[idx] = emerge;
    @(negedge clk);
    total++;
    if (mem_wr !== 1'b0 || d_ack !== 1'b0 || mem_addr !== 32'h0) begin
      bad++; $display("FAIL rst_mid_idle: mem_wr=%b d_ack=%b mem_addr=%h want 0 0 0", mem_wr, d_ack, mem_addr);
    end
    reset = 1'b0;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (d_ack || if_ack) acks++;
    end
    total++;
    if (acks !== 0) begin bad++; $display("FAIL rst_mid_noack: got %0d acks want 0", acks); end
    run_txn(1'b0, 1'b0, 2'd3, 32'h308, '0);
    total++;
    if (r_lat !== MEM_LAT + 2 || d_rdata !== ref_mem[idx]) begin
      bad++; $display("FAIL rst_mid_fresh: lat=%0d data=%h want %0d %h", r_lat, d_rdata, MEM_LAT + 2, ref_mem[idx]);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) preset(i, {$urandom, $urandom});
    test_reset;
    test_fetch;
    test_store_byte;
    test_store_dword;
    test_misaligned;
    test_random;
    test_starvation;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
